// File: rtl/wb_reg_responder_pkg.sv
// wb_reg_responder shared definitions
// Register map, FLAGS bit layout and FSM encoding
package wb_reg_responder_pkg;

  localparam logic [2:0] REG_ID      = 3'd0;
  localparam logic [2:0] REG_CTRL    = 3'd1;
  localparam logic [2:0] REG_STATUS  = 3'd2;
  localparam logic [2:0] REG_FLAGS   = 3'd3;
  localparam logic [2:0] REG_MASK    = 3'd4;
  localparam logic [2:0] REG_SCRATCH = 3'd5;
  localparam logic [2:0] REG_TXD     = 3'd6;
  localparam logic [2:0] REG_RXD     = 3'd7;

  localparam int FLAG_RXF     = 0;
  localparam int FLAG_OVR     = 1;
  localparam int FLAG_EVT_LSB = 2;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    ACK  = 2'd2
  } state_t;

  typedef struct packed {
    logic       we;
    logic [2:0] adr;
    logic [7:0] dat;
  } wb_req_t;

endpackage

// File: rtl/wb_reg_responder_event_flags.sv
// wb_event_flags: event/rx flag block
// Edge detect, RXF/OVR, W1C with set priority, MASK, IRQ
module wb_event_flags
  import wb_reg_responder_pkg::*;
(
  input  logic       i_clk,
  input  logic       i_reset_n,
  input  logic       i_rx_valid,
  input  logic [5:0] i_event,
  input  logic       i_rxd_rd,
  input  logic [7:0] i_w1c,
  input  logic       i_mask_we,
  input  logic [7:0] i_mask_dat,
  output logic [7:0] o_flags,
  output logic [7:0] o_mask,
  output logic       o_irq
);

  logic [5:0] event_q;
  logic [7:0] set_v;
  logic [7:0] clr_v;

  // set and clear vectors; set is applied last so it wins
  always_comb begin
    set_v = '0;
    clr_v = i_w1c;
    set_v[FLAG_RXF] = i_rx_valid;
    set_v[FLAG_OVR] = i_rx_valid
                    & o_flags[FLAG_RXF]
                    & ~i_rxd_rd;
    set_v[7:FLAG_EVT_LSB] = i_event & ~event_q;
    clr_v[FLAG_RXF] = i_w1c[FLAG_RXF] | i_rxd_rd;
  end

  // flag, mask, event history and irq registers
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      o_flags <= '0;
      o_mask  <= '0;
      event_q <= '0;
      o_irq   <= 1'b0;
    end else begin
      o_flags <= (o_flags & ~clr_v) | set_v;
      event_q <= i_event;
      o_irq   <= |(o_flags & o_mask);
      if (i_mask_we) o_mask <= i_mask_dat;
    end
  end

endmodule

// File: rtl/wb_reg_responder.sv
// wb_reg_responder: Wishbone classic byte register slave
// Eight 8-bit registers with configurable ack latency
module wb_reg_responder
  import wb_reg_responder_pkg::*;
#(
  parameter logic [7:0] ID_VALUE    = 8'hA5,
  parameter int         WAIT_STATES = 0
) (
  input  logic       i_clk,
  input  logic       i_reset_n,
  input  logic [2:0] i_wbs_adr,
  input  logic [7:0] i_wbs_dat,
  output logic [7:0] o_wbs_dat,
  input  logic       i_wbs_we,
  input  logic       i_wbs_stb,
  input  logic       i_wbs_cyc,
  output logic       o_wbs_ack,
  output logic [7:0] o_ctrl,
  input  logic [7:0] i_status,
  output logic [7:0] o_tx_data,
  output logic       o_tx_valid,
  input  logic [7:0] i_rx_data,
  input  logic       i_rx_valid,
  input  logic [5:0] i_event,
  output logic       o_irq
);

  localparam logic [3:0] WS = 4'(WAIT_STATES);

  state_t     state, state_n;
  logic [3:0] cnt, cnt_n;
  wb_req_t    req, req_n, cur;
  logic       commit;
  logic       wr, rd;
  logic [7:0] rdata;
  logic [7:0] scratch;
  logic [7:0] rxd;
  logic [7:0] flags;
  logic [7:0] mask;

  // next state; commit marks the edge that raises ack
  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    req_n   = req;
    cur     = req;
    commit  = 1'b0;
    unique case (1'b1)
      (state == IDLE): begin
        if (i_wbs_cyc && i_wbs_stb) begin
          req_n.we  = i_wbs_we;
          req_n.adr = i_wbs_adr;
          req_n.dat = i_wbs_dat;
          cur       = req_n;
          if (WS == 4'd0) begin
            state_n = ACK;
            commit  = 1'b1;
          end else begin
            cnt_n   = WS;
            state_n = WAIT;
          end
        end
      end
      (state == WAIT): begin
        if (!(i_wbs_cyc && i_wbs_stb)) begin
          state_n = IDLE;
        end else if (cnt == 4'd1) begin
          state_n = ACK;
          commit  = 1'b1;
        end else begin
          cnt_n = cnt - 4'd1;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  assign wr = commit & cur.we;
  assign rd = commit & ~cur.we;

  // read mux, evaluated with pre-commit register values
  always_comb begin
    rdata = '0;
    unique case (cur.adr)
      REG_ID:      rdata = ID_VALUE;
      REG_CTRL:    rdata = o_ctrl;
      REG_STATUS:  rdata = i_status;
      REG_FLAGS:   rdata = flags;
      REG_MASK:    rdata = mask;
      REG_SCRATCH: rdata = scratch;
      REG_TXD:     rdata = o_tx_data;
      REG_RXD:     rdata = rxd;
    endcase
  end

  // FSM, bus outputs and plain registers
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state      <= IDLE;
      cnt        <= '0;
      req        <= '0;
      o_wbs_ack  <= 1'b0;
      o_wbs_dat  <= '0;
      o_tx_valid <= 1'b0;
      o_tx_data  <= '0;
      o_ctrl     <= '0;
      scratch    <= '0;
      rxd        <= '0;
    end else begin
      state      <= state_n;
      cnt        <= cnt_n;
      req        <= req_n;
      o_wbs_ack  <= commit;
      o_wbs_dat  <= rd ? rdata : 8'h00;
      o_tx_valid <= wr && (cur.adr == REG_TXD);
      if (i_rx_valid) rxd <= i_rx_data;
      if (wr) begin
        unique case (1'b1)
          (cur.adr == REG_CTRL):    o_ctrl    <= cur.dat;
          (cur.adr == REG_SCRATCH): scratch   <= cur.dat;
          (cur.adr == REG_TXD):     o_tx_data <= cur.dat;
          default: ;
        endcase
      end
    end
  end

  wb_event_flags u_flags (
    .i_clk      (i_clk),
    .i_reset_n  (i_reset_n),
    .i_rx_valid (i_rx_valid),
    .i_event    (i_event),
    .i_rxd_rd   (rd && (cur.adr == REG_RXD)),
    .i_w1c      ((wr && (cur.adr == REG_FLAGS))
                 ? cur.dat : 8'h00),
    .i_mask_we  (wr && (cur.adr == REG_MASK)),
    .i_mask_dat (cur.dat),
    .o_flags    (flags),
    .o_mask     (mask),
    .o_irq      (o_irq)
  );

endmodule

// File: tb/tb_wb_reg_responder.sv
// tb_wb_reg_responder: scoreboard bench
// Two instances: zero and three wait states
module tb_wb_reg_responder;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       b_cyc = 1'b0, b_stb = 1'b0, b_we = 1'b0;
  logic [2:0] b_adr = '0;
  logic [7:0] b_dat = '0;
  logic [7:0] s_status = '0, s_rx_data = '0;
  logic       s_rx_valid = 1'b0;
  logic [5:0] s_event = '0;
  logic       sel = 1'b0;
  int         ws = 0;

  logic       ack0, ack3, txv0, txv3, irq0, irq3;
  logic [7:0] dat0, dat3, ctrl0, ctrl3, txd0, txd3;
  logic       ack, txv, irq;
  logic [7:0] dat, ctrl, txd;

  assign ack  = sel ? ack3  : ack0;
  assign txv  = sel ? txv3  : txv0;
  assign irq  = sel ? irq3  : irq0;
  assign dat  = sel ? dat3  : dat0;
  assign ctrl = sel ? ctrl3 : ctrl0;
  assign txd  = sel ? txd3  : txd0;

  always #5 clk = ~clk;

  wb_reg_responder #(.ID_VALUE(8'hA5), .WAIT_STATES(0)) dut0 (
    .i_clk(clk), .i_reset_n(rst_n),
    .i_wbs_adr(b_adr), .i_wbs_dat(b_dat), .o_wbs_dat(dat0),
    .i_wbs_we(b_we), .i_wbs_stb(b_stb & ~sel),
    .i_wbs_cyc(b_cyc & ~sel), .o_wbs_ack(ack0),
    .o_ctrl(ctrl0), .i_status(s_status),
    .o_tx_data(txd0), .o_tx_valid(txv0),
    .i_rx_data(s_rx_data), .i_rx_valid(s_rx_valid),
    .i_event(s_event), .o_irq(irq0)
  );

  wb_reg_responder #(.ID_VALUE(8'hA5), .WAIT_STATES(3)) dut3 (
    .i_clk(clk), .i_reset_n(rst_n),
    .i_wbs_adr(b_adr), .i_wbs_dat(b_dat), .o_wbs_dat(dat3),
    .i_wbs_we(b_we), .i_wbs_stb(b_stb & sel),
    .i_wbs_cyc(b_cyc & sel), .o_wbs_ack(ack3),
    .o_ctrl(ctrl3), .i_status(s_status),
    .o_tx_data(txd3), .o_tx_valid(txv3),
    .i_rx_data(s_rx_data), .i_rx_valid(s_rx_valid),
    .i_event(s_event), .o_irq(irq3)
  );

  typedef struct {
    int         cyc;
    logic [7:0] rd;
    bit         rd_chk;
    bit         tx;
  } exp_t;

  exp_t q[$];
  exp_t e_m;
  int   checks = 0;
  int   failures = 0;
  int   cyc_n = 0;
  bit   mon_en = 1'b0;
  bit   rnd_side = 1'b0;

  logic [7:0] m_ctrl, m_mask, m_scr, m_txd, m_rxd, m_flags;
  logic [5:0] m_evq;
  logic       m_irq;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s cyc=%0d got=%h want=%h", nm, cyc_n, act, exp);
    end
  endtask

  function automatic void model_clear();
    m_ctrl = '0; m_mask = '0; m_scr = '0; m_txd = '0;
    m_rxd = '0; m_flags = '0; m_evq = '0; m_irq = 1'b0;
  endfunction

  function automatic logic [7:0] reg_val(input logic [2:0] a);
    case (a)
      3'd0: return 8'hA5;
      3'd1: return m_ctrl;
      3'd2: return s_status;
      3'd3: return m_flags;
      3'd4: return m_mask;
      3'd5: return m_scr;
      3'd6: return m_txd;
      default: return m_rxd;
    endcase
  endfunction

  // one clock edge: apply register-map rules, then drive side inputs
  task automatic edge_(input bit commit);
    logic [7:0] rdv, nf;
    logic       irq_n, rxd_read;
    @(posedge clk);
    cyc_n++;
    if (rst_n) begin
      irq_n = |(m_flags & m_mask);
      rdv = reg_val(b_adr);
      nf = m_flags;
      rxd_read = commit && !b_we && (b_adr == 3'd7);
      if (commit) begin
        q.push_back('{cyc: cyc_n, rd: rdv, rd_chk: !b_we,
                      tx: b_we && (b_adr == 3'd6)});
        if (b_we) begin
          case (b_adr)
            3'd1: m_ctrl = b_dat;
            3'd3: nf = nf & ~b_dat;
            3'd4: m_mask = b_dat;
            3'd5: m_scr = b_dat;
            3'd6: m_txd = b_dat;
            default: ;
          endcase
        end else if (rxd_read) nf[0] = 1'b0;
      end
      if (s_rx_valid) begin
        if (m_flags[0] && !rxd_read) nf[1] = 1'b1;
        nf[0] = 1'b1;
        m_rxd = s_rx_data;
      end
      nf[7:2] = nf[7:2] | (s_event & ~m_evq);
      m_flags = nf;
      m_evq = s_event;
      m_irq = irq_n;
    end
    @(negedge clk);
    if (rnd_side) begin
      s_status = 8'($urandom);
      s_rx_valid = ($urandom_range(0, 3) == 0);
      s_rx_data = 8'($urandom);
      if ($urandom_range(0, 3) == 0) s_event = 6'($urandom);
    end else begin
      s_rx_valid = 1'b0;
    end
  endtask

  task automatic do_reset(input logic new_sel);
    chk("pending_at_reset", q.size(), 0);
    #2;
    rst_n = 1'b0;
    sel = new_sel;
    ws = new_sel ? 3 : 0;
    b_cyc = 1'b0; b_stb = 1'b0;
    s_rx_valid = 1'b0; s_event = '0;
    model_clear();
    #1;
    chk("rst_ack", ack, 0);
    chk("rst_dat", dat, 0);
    chk("rst_txv", txv, 0);
    repeat (3) edge_(1'b0);
    #2;
    rst_n = 1'b1;
  endtask

  // full transaction; abort_k>0 drops cyc or stb before edge E+abort_k
  task automatic xfer(input logic we, input logic [2:0] adr,
                      input logic [7:0] d, input int abort_k);
    bit hold;
    hold = 1'($urandom_range(0, 1));
    b_cyc = 1'b1; b_stb = 1'b1;
    b_we = we; b_adr = adr; b_dat = d;
    for (int k = 0; k <= ws; k++) begin
      if (k != 0 && k == abort_k) begin
        if ($urandom_range(0, 1) == 1) b_cyc = 1'b0;
        else b_stb = 1'b0;
        edge_(1'b0);
        b_cyc = 1'b0; b_stb = 1'b0;
        return;
      end
      edge_(k == ws);
    end
    if (!hold) begin b_cyc = 1'b0; b_stb = 1'b0; end
    edge_(1'b0);
    b_cyc = 1'b0; b_stb = 1'b0;
  endtask

  task automatic tb_rd(input logic [2:0] a);
    xfer(1'b0, a, 8'h00, 0);
  endtask

  task automatic tb_wr(input logic [2:0] a, input logic [7:0] d);
    xfer(1'b1, a, d, 0);
  endtask

  task automatic rand_xfer(input int abort_pct);
    logic       we;
    logic [2:0] a;
    logic [7:0] d;
    int         ab;
    we = 1'($urandom_range(0, 1));
    a = 3'($urandom);
    d = 8'($urandom);
    ab = 0;
    if (ws > 0 && $urandom_range(0, 99) < abort_pct)
      ab = $urandom_range(1, ws);
    xfer(we, a, d, ab);
    repeat ($urandom_range(0, 2)) edge_(1'b0);
  endtask

  // monitor: pop an expectation on every ack, watch outputs every cycle
  always @(negedge clk) begin
    if (mon_en) begin
      if (ack) begin
        if (q.size() == 0) begin
          chk("spurious_ack", ack, 0);
        end else begin
          e_m = q.pop_front();
          chk("ack_cycle", cyc_n, e_m.cyc);
          if (e_m.rd_chk) chk("rdata", dat, e_m.rd);
          chk("tx_valid", txv, e_m.tx);
        end
      end else begin
        chk("idle_dat", dat, 0);
        chk("idle_txv", txv, 0);
      end
      chk("irq", irq, m_irq);
      chk("ctrl", ctrl, m_ctrl);
      chk("tx_data", txd, m_txd);
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog cyc=%0d got=running want=done", cyc_n);
    $fatal(1);
  end

  initial begin
    model_clear();
    do_reset(1'b0);
    mon_en = 1'b1;

    tb_rd(3'd0);
    tb_rd(3'd5);
    tb_wr(3'd1, 8'h3C);
    tb_rd(3'd1);
    tb_wr(3'd0, 8'hFF);
    tb_rd(3'd0);
    tb_wr(3'd6, 8'h55);
    s_rx_data = 8'h11; s_rx_valid = 1'b1;
    edge_(1'b0);
    s_rx_data = 8'h22; s_rx_valid = 1'b1;
    edge_(1'b0);
    tb_rd(3'd3);
    tb_rd(3'd7);
    tb_rd(3'd3);
    tb_wr(3'd3, 8'h02);
    tb_rd(3'd3);
    tb_wr(3'd4, 8'h04);
    s_event = 6'h01;
    repeat (3) edge_(1'b0);
    tb_wr(3'd3, 8'h04);
    s_event = 6'h00;
    edge_(1'b0);
    s_event = 6'h01;
    tb_wr(3'd3, 8'h04);
    tb_rd(3'd3);
    edge_(1'b0);

    rnd_side = 1'b1;
    repeat (300) rand_xfer(0);
    rnd_side = 1'b0;
    repeat (3) edge_(1'b0);

    do_reset(1'b1);
    tb_rd(3'd0);
    tb_wr(3'd5, 8'h5A);
    xfer(1'b1, 3'd5, 8'hC3, 2);
    xfer(1'b1, 3'd1, 8'h77, 3);
    tb_rd(3'd5);
    tb_rd(3'd1);
    b_cyc = 1'b1; b_stb = 1'b1;
    b_we = 1'b1; b_adr = 3'd1; b_dat = 8'hC3;
    edge_(1'b0);
    edge_(1'b0);
    do_reset(1'b1);
    repeat (4) edge_(1'b0);
    tb_rd(3'd1);

    rnd_side = 1'b1;
    repeat (150) rand_xfer(30);
    rnd_side = 1'b0;
    repeat (4) edge_(1'b0);
    chk("pending_at_end", q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
